aes_inv_cipher_seq: RTL and testbench

- Iterative AES-128 decryption sequencer. It sits directly upstream of inv_round: it feeds inv_round one round per clock and registers its state and key outputs.
- Performs the initial AddRoundKey with the round-10 key, 9 full inverse rounds through inv_round, then a final round without InvMixColumns.
- Presents a valid/ready stream on both sides, to the surrounding Pass-Keeper datapath.

---
 rtl/aes_pkg.sv | 85 ++++++++
 rtl/inv_keygen.sv | 29 ++
 rtl/inv_round.sv | 46 ++++
 rtl/inv_shift_rows.sv | 19 +
 rtl/inv_subbytes.sv | 14 +
 rtl/aes_inv_cipher_seq.sv | 123 ++++++++++++
 tb/tb_aes_inv_cipher_seq.sv | 319 +++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the
// iterative inverse cipher: S-boxes, field multiply and round constants.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int BLOCK_W    = 128;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), with 0 -> 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, s);
            s = gmul(s, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] i;
        i = gf_inv(b);
        return i
             ^ {i[6:0], i[7]}
             ^ {i[5:0], i[7:6]}
             ^ {i[4:0], i[7:5]}
             ^ {i[3:0], i[7:4]}
             ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]}
          ^ {b[4:0], b[7:5]}
          ^ {b[1:0], b[7:2]}
          ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rn);
        logic [7:0] r;
        case (rn)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inv_keygen.sv
// Backward AES-128 key schedule step: derives round key K(n-1) from K(n).
// Ports: keyin (K(n)), round_num (n, 1..10), keyout (K(n-1)).
module inv_keygen
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] keyin,
    input  logic [3:0]         round_num,
    output logic [BLOCK_W-1:0] keyout
);

    logic [31:0] a0, a1, a2, a3;
    logic [31:0] b3;
    logic [31:0] rot;
    logic [31:0] sub;

    assign {a0, a1, a2, a3} = keyin;

    // Later words are running XORs, so neighbouring words undo them.
    assign b3  = a3 ^ a2;
    assign rot = {b3[23:0], b3[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]),
                  sbox(rot[15:8]),  sbox(rot[7:0])};

    assign keyout = {a0 ^ sub ^ {rcon(round_num), 24'h0},
                     a1 ^ a0,
                     a2 ^ a1,
                     b3};

endmodule

// File: rtl/inv_round.sv
// One full AES inverse round plus the matching backward key step.
// Ports: in/keyin (state, K(n)), round_num, out (next state), keyout.
module inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] in,
    input  logic [3:0]         round_num,
    input  logic [BLOCK_W-1:0] keyin,
    output logic [BLOCK_W-1:0] out,
    output logic [BLOCK_W-1:0] keyout
);

    logic [BLOCK_W-1:0] sr;
    logic [BLOCK_W-1:0] sb;
    logic [BLOCK_W-1:0] ark;

    inv_shift_rows u_isr (
        .in  (in),
        .out (sr)
    );

    inv_subbytes u_isb (
        .in  (sr),
        .out (sb)
    );

    inv_keygen u_kg (
        .keyin     (keyin),
        .round_num (round_num),
        .keyout    (keyout)
    );

    assign ark = sb ^ keyout;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] s0, s1, s2, s3;
        assign {s0, s1, s2, s3} = ark[BLOCK_W-1-32*c -: 32];
        assign out[BLOCK_W-1-32*c -: 32] = {
            gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09),
            gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d),
            gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b),
            gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e)
        };
    end

endmodule

// File: rtl/inv_shift_rows.sv
// AES InvShiftRows: row r of the column-major state rotates right by r.
// Ports: in (state), out (permuted state). Purely combinational.
module inv_shift_rows
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] in,
    output logic [BLOCK_W-1:0] out
);

    // Byte k (MSB first) sits at row k%4, column k/4.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = 4 * c + r;
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            assign out[BLOCK_W-1-8*DST -: 8] = in[BLOCK_W-1-8*SRC -: 8];
        end
    end

endmodule

// File: rtl/inv_subbytes.sv
// AES InvSubBytes: inverse S-box applied to all 16 state bytes.
// Ports: in (state), out (substituted state). Purely combinational.
module inv_subbytes
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] in,
    output logic [BLOCK_W-1:0] out
);

    for (genvar k = 0; k < 16; k++) begin : g_byte
        assign out[8*k +: 8] = inv_sbox(in[8*k +: 8]);
    end

endmodule

// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES-128 decryptor: one inverse round per clock, valid/ready
// on both sides. Ports: clk, rst, in_*/ciphertext/key_last, out_*/plaintext, busy.
module aes_inv_cipher_seq
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int DATA_W     = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ciphertext,
    input  logic [DATA_W-1:0] key_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] plaintext,
    output logic              busy
);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("aes_inv_cipher_seq: only NUM_ROUNDS=10 is supported");
    end
    if (DATA_W != 128) begin : g_bad_width
        $error("aes_inv_cipher_seq: DATA_W must be 128");
    end

    fsm_t              fsm_q, fsm_n;
    logic [DATA_W-1:0] state_reg, state_n;
    logic [DATA_W-1:0] key_reg, key_n;
    logic [3:0]        rc, rc_n;
    logic [DATA_W-1:0] pt_q, pt_n;
    logic              ov_q, ov_n;

    logic [3:0]        r_num;
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] r_key;
    logic [DATA_W-1:0] fin_sr;
    logic [DATA_W-1:0] fin_sb;

    // Outside ROUND the round number parks at 1 so it never hits 0 or >10.
    assign r_num = (fsm_q == ROUND) ? rc : 4'd1;

    inv_round u_round (
        .in        (state_reg),
        .round_num (r_num),
        .keyin     (key_reg),
        .out       (r_out),
        .keyout    (r_key)
    );

    // Final round skips InvMixColumns, so it has its own short path.
    inv_shift_rows u_fin_sr (
        .in  (state_reg),
        .out (fin_sr)
    );

    inv_subbytes u_fin_sb (
        .in  (fin_sr),
        .out (fin_sb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rc        <= '0;
            pt_q      <= '0;
            ov_q      <= 1'b0;
        end else begin
            fsm_q     <= fsm_n;
            state_reg <= state_n;
            key_reg   <= key_n;
            rc        <= rc_n;
            pt_q      <= pt_n;
            ov_q      <= ov_n;
        end
    end

    always_comb begin
        fsm_n   = fsm_q;
        state_n = state_reg;
        key_n   = key_reg;
        rc_n    = rc;
        pt_n    = pt_q;
        ov_n    = ov_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_n = ciphertext ^ key_last;
                    key_n   = key_last;
                    rc_n    = 4'(NUM_ROUNDS);
                    fsm_n   = ROUND;
                end
            end
            ROUND: begin
                state_n = r_out;
                key_n   = r_key;
                rc_n    = rc - 4'd1;
                if (rc == 4'd2) fsm_n = FINAL;
            end
            FINAL: begin
                pt_n  = fin_sb ^ r_key;
                ov_n  = 1'b1;
                fsm_n = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ov_n  = 1'b0;
                    fsm_n = IDLE;
                end
            end
            default: fsm_n = IDLE;
        endcase
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q == ROUND) || (fsm_q == FINAL);
    assign out_valid = ov_q;
    assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_seq.sv
// Testbench for aes_inv_cipher_seq: FIPS-197 vectors plus random blocks
// produced by a forward AES-128 encryption model.
`timescale 1ns/1ps
module tb_aes_inv_cipher_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready, out_valid, busy;
    logic [127:0] ciphertext = '0;
    logic [127:0] key_last = '0;
    logic [127:0] plaintext;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_S1 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_K   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_inv_cipher_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key_last   (key_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // ---- forward AES-128 reference model ----
    function automatic logic [7:0] rl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4) ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] b, input int i);
        return b[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] b);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sb[gb(b, i)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] b);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = gb(b, 4*((c+r)%4)+r);
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] b);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(b, 4*c);   a1 = gb(b, 4*c+1);
            a2 = gb(b, 4*c+2); a3 = gb(b, 4*c+3);
            o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k,
                                              input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t = {sb[w3[23:16]] ^ rc, sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic aes_enc(input logic [127:0] pt, input logic [127:0] k0,
                           output logic [127:0] ct, output logic [127:0] k10);
        logic [127:0] s, k;
        logic [7:0] rc;
        k  = k0;
        rc = 8'h01;
        s  = pt ^ k;
        for (int r = 1; r <= 10; r++) begin
            k  = next_key(k, rc);
            rc = xt(rc);
            s  = shift_rows(sub_bytes(s));
            if (r != 10) s = mix_columns(s);
            s = s ^ k;
        end
        ct  = s;
        k10 = k;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---- drive / wait helpers ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1'b1);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("out_valid_wait", out_valid, 1'b1);
    endtask

    task automatic send(input logic [127:0] ct, input logic [127:0] k);
        wait_ready();
        in_valid   = 1'b1;
        ciphertext = ct;
        key_last   = k;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [127:0] ct,
                           input logic [127:0] k, input logic [127:0] pt);
        int lat;
        send(ct, k);
        wait_out(lat);
        check({tag, "_lat"}, lat, 10);
        check({tag, "_pt"}, plaintext, pt);
        tick();
    endtask

    initial begin
        int lat, n;
        logic [127:0] p1, k1, c1, q1, p2, k2, c2, q2;
        logic [127:0] bp [3], bc [3], bk [3];
        int t [3];

        build_sbox();

        // reset state
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pt", plaintext, '0);
        rst = 1'b0;

        // FIPS-197 C.1 with first-round state check
        send(C1_CT, C1_K);
        check("c1_state", dut.state_reg, C1_S1);
        check("c1_busy", busy, 1'b1);
        wait_out(lat);
        check("c1_lat", lat, 10);
        check("c1_pt", plaintext, C1_PT);
        tick();

        // FIPS-197 Appendix B
        run_one("appb", B_CT, B_K, B_PT);

        // random blocks from the forward model
        for (int i = 0; i < 6; i++) begin
            p1 = rnd128();
            k1 = rnd128();
            aes_enc(p1, k1, c1, q1);
            run_one($sformatf("rnd%0d", i), c1, q1, p1);
        end

        // backpressure with a second block pending
        p1 = rnd128(); k1 = rnd128(); aes_enc(p1, k1, c1, q1);
        p2 = rnd128(); k2 = rnd128(); aes_enc(p2, k2, c2, q2);
        out_ready = 1'b0;
        send(c1, q1);
        in_valid   = 1'b1;
        ciphertext = c2;
        key_last   = q2;
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_pt_hold", plaintext, p1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_ov_hold", out_valid, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_ov", out_valid, 1'b0);
        check("bp_release_rdy", in_ready, 1'b1);
        check("bp_release_busy", busy, 1'b0);
        tick();
        check("bp_second_acc", busy, 1'b1);
        in_valid = 1'b0;
        wait_out(lat);
        check("bp_second_lat", lat, 10);
        check("bp_second_pt", plaintext, p2);
        tick();

        // reset mid-operation
        send(C1_CT, C1_K);
        n = 0;
        while (dut.rc != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        check("mrst_rc5", dut.rc, 4'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_in_ready", in_ready, 1'b1);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_pt", plaintext, '0);
        run_one("mrst_c1", C1_CT, C1_K, C1_PT);

        // inputs toggled while busy are ignored
        send(C1_CT, C1_K);
        n = 0;
        while (busy && n < 40) begin
            in_valid   = 1'($urandom_range(0, 1));
            ciphertext = rnd128();
            key_last   = rnd128();
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("ign_busy_cycles", n, 10);
        check("ign_out_valid", out_valid, 1'b1);
        check("ign_pt", plaintext, C1_PT);
        tick();

        // back-to-back with in_valid and out_ready tied high
        for (int i = 0; i < 3; i++) begin
            bp[i] = rnd128();
            aes_enc(bp[i], rnd128(), bc[i], bk[i]);
        end
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        ciphertext = bc[0];
        key_last   = bk[0];
        for (int i = 0; i < 3; i++) begin
            wait_ready();
            tick();
            t[i] = cyc;
            if (i < 2) begin
                ciphertext = bc[i+1];
                key_last   = bk[i+1];
            end
            wait_out(lat);
            if (i == 2) in_valid = 1'b0;
            check($sformatf("b2b_pt%0d", i), plaintext, bp[i]);
            if (i > 0) check($sformatf("b2b_gap%0d", i), t[i] - t[i-1], 12);
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
